instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Producer side of the instruction interface: generates the fetch PC, reads a synchronous instruction memory and supplies instruction words to the decoder through a valid/ready handshake.
- Holds fetched words in a small FIFO so the decoder can stall without losing data.
- Accepts a redirect (taken branch/jump resolved downstream), flushes stale words and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries; power of two, at least 2.
- NOP_INSTR, 32'h0000_0013, value driven on instr_out while instr_valid=0 (ADDI x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  32  fetch byte address; bits [1:0] always 0.
- imem_rdata  input  32  memory data; valid exactly one cycle after the imem_req cycle.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  restart address; bits [1:0] ignored and forced to 0.
- instr_out  output  32  instruction at FIFO head.
- pc_out  output  32  byte address of instr_out.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  decoder accepts head this cycle.

Behaviour:
- Reset (rst=1 at an edge): fetch_pc<=RESET_PC, FIFO count<=0, in-flight<=0, squash<=0. While rst=1: imem_req=0, instr_valid=0, instr_out=NOP_INSTR, pc_out=0.
- Accept: instr_valid && instr_ready at an edge pops the head.
- Request rule: imem_req = !rst && !redirect_valid && (count+inflight < DEPTH, or an accept occurs this cycle). imem_addr=fetch_pc. At an edge with imem_req=1: fetch_pc<=fetch_pc+4 (wraps mod 2^32), inflight<=1, and the issued address is recorded.
- Response: in the cycle after a request, imem_rdata and the recorded address are pushed at the next edge unless squashed. instr_valid rises the cycle after the push.
- Latency: request in cycle N, data on imem_rdata in cycle N+1, instr_valid in cycle N+2.
- Throughput: with instr_ready held at 1, one instruction per cycle after warm-up, with no bubbles.
- Full FIFO: no request is issued. The FIFO never overflows because count+inflight never exceeds DEPTH.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- Redirect (redirect_valid=1 at an edge):
  - FIFO count<=0 and fetch_pc<={redirect_pc[31:2],2'b00}.
  - Any response arriving in the next cycle is discarded (squash).
  - No request in the redirect cycle. The first request to the new PC is in the following cycle.
  - A redirect takes priority over a push in the same cycle.
  - An accept in the redirect cycle is still a valid handshake; the decoder consumed it.
- Back-to-back redirects: the last one wins. Each clears the FIFO and re-arms squash.
- Ordering: instructions leave in strictly increasing PC order (+4) between redirects. pc_out always matches instr_out.
- Reset mid-operation: a synchronous reset overrides redirect and every handshake. The in-flight response is dropped.
- Outputs instr_out and pc_out are driven straight from the FIFO head, with no combinational path from instr_ready.

Test Plan:
- Reset release, RESET_PC=0, memory word = address, instr_ready=1 -> imem_addr 0,4,8 on consecutive cycles; instr_valid from cycle 2; pc_out/instr_out = 0/0, 4/4, 8/8, one per cycle.
- instr_ready=0 for 6 cycles after warm-up -> exactly DEPTH words buffered, imem_req=0 while full; on ready=1 the words 0,4 come out in order with nothing lost or duplicated.
- Redirect to 32'h0000_0103 while FIFO holds 8,12 -> instr_valid=0 the next cycle; next request address 0x100; in-flight word from 16 never appears; first output pc_out=0x100.
- Redirect on two consecutive cycles (0x200 then 0x300) -> no 0x200 word is output; first output is 0x300.
- Fetch starting at 32'hFFFF_FFF8 -> addresses FFF8, FFFC, 0000, 0004 delivered in order.
- Assert rst for one cycle mid-stream with FIFO full -> next cycle instr_valid=0, instr_out=NOP_INSTR; fetch restarts at RESET_PC; no pre-reset word emitted.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the fetch PC into a synchronous instruction
// memory, buffers returned words in a small FIFO, and hands them to the
// decoder over a valid/ready handshake. A redirect flushes the buffer and
// restarts fetch at the new PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic          squash_q, squash_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic          accept;
    logic          push;
    logic [CW:0]   occupancy;

    // Handshake, request decision and next-state for the fetch pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        squash_d   = squash_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        instr_valid = (count_q != '0) && !rst;
        accept      = instr_valid && instr_ready;
        // Counting the in-flight slot guarantees room for the response.
        occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        imem_req    = !rst && !redirect_valid &&
                      ((occupancy < (CW+1)'(DEPTH)) || accept);
        push        = inflight_q && !squash_q && !redirect_valid;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            inflight_d = 1'b0;
            squash_d   = 1'b1;
        end else begin
            squash_d   = 1'b0;
            inflight_d = imem_req;
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (accept) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign instr_out = instr_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    assign pc_out    = instr_valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;

endmodule
